// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receive front-end. Synchronises the raw serial line,
//   detects the start edge, votes each bit 2-of-3 around mid-bit and emits
//   one-cycle strobes for good frames and framing/parity errors.
//   Default frame format is 8N1, LSB first.
//
//   Build option: define UART_RX_PARITY_EN for 8E1 (even parity bit between
//   the data bits and the stop bit).
//
// Ports
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   i_rx           in   raw serial input, asynchronous, idle high
//   o_received     out  one-cycle pulse, o_rx_byte just updated with a good frame
//   o_rx_byte      out  last correctly received byte, held until next good frame
//   o_is_receiving out  high from start-edge detection until return to IDLE
//   o_recv_error   out  one-cycle pulse on framing (or parity) error
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on the synchronised rx
// START    | validating the start bit; a high vote means it was a glitch
// DATA     | shifting in 8 data bits, LSB first
// PARITY   | voting the even-parity bit (UART_RX_PARITY_EN only)
// STOP     | voting the stop bit, emitting received or recv_error
// BREAK    | line stuck low after a framing error, waiting for it to rise

module uart_receiver #(
    parameter int CLK_FREQ   = 5000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_received,
    output logic [7:0] o_rx_byte,
    output logic       o_is_receiving,
    output logic       o_recv_error
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;

    if (DIV < 1) begin : g_div_check
        $error("uart_receiver: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV = 0)");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_receiver: OVERSAMPLE must be >= 8 and even");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic             r_rx_meta;
    logic             r_rxs;
    logic             r_rxs_d;
    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [S_W-1:0]   r_s;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_v0;
    logic             r_v1;
    logic             r_received;
    logic             r_recv_error;
    logic [7:0]       r_rx_byte;
`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             w_par_ok;
`endif

    logic w_tick;
    logic w_vote_now;
    logic w_vote;
    logic w_start_edge;

    assign w_tick       = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_vote_now   = w_tick && (r_s == S_W'(M + 1));
    // Third sample is the live synchronised value on the M+1 tick.
    assign w_vote       = (r_v0 & r_v1) | (r_v0 & r_rxs) | (r_v1 & r_rxs);
    // Requiring the previous value high also enforces the one-clock-high
    // gap after BREAK before a new start is accepted.
    assign w_start_edge = r_rxs_d & ~r_rxs;
`ifdef UART_RX_PARITY_EN
    assign w_par_ok     = ~(^{r_shift, r_par});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rxs        <= 1'b1;
            r_rxs_d      <= 1'b1;
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_s          <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_v0         <= 1'b1;
            r_v1         <= 1'b1;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;
            r_rx_byte    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= i_rx;
            r_rxs        <= r_rx_meta;
            r_rxs_d      <= r_rxs;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;

            // Counters idle at zero so the first tick lines up with the edge.
            if (r_state == S_IDLE) begin
                r_div_cnt <= '0;
                r_s       <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_s       <= (r_s == S_W'(OVERSAMPLE - 1)) ? '0 : r_s + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (w_tick && r_s == S_W'(M - 1)) r_v0 <= r_rxs;
            if (w_tick && r_s == S_W'(M))     r_v1 <= r_rxs;

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= S_START;
                        r_bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (w_vote_now) r_state <= w_vote ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_vote_now) begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_vote_now) begin
                        r_par   <= w_vote;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_vote_now) begin
                        if (!w_vote) begin
                            r_recv_error <= 1'b1;
                            r_state      <= S_BREAK;
                        end else if (w_par_ok) begin
                            r_received <= 1'b1;
                            r_rx_byte  <= r_shift;
                            r_state    <= S_IDLE;
                        end else begin
                            // Line is back high, so no need to wait in BREAK.
                            r_recv_error <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
`else
                S_STOP: begin
                    if (w_vote_now) begin
                        if (w_vote) begin
                            r_received <= 1'b1;
                            r_rx_byte  <= r_shift;
                            r_state    <= S_IDLE;
                        end else begin
                            r_recv_error <= 1'b1;
                            r_state      <= S_BREAK;
                        end
                    end
                end
`endif
                S_BREAK: begin
                    if (r_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_received     = r_received;
    assign o_recv_error   = r_recv_error;
    assign o_rx_byte      = r_rx_byte;
    assign o_is_receiving = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver at 32 clocks per bit (DIV = 2).
//   Frame stimulus is driven on the falling clock edge; outputs are sampled
//   on the falling edge by a monitor that records every strobe.
//   Parity vectors are built only when UART_RX_PARITY_EN is defined.

module tb_uart_receiver;

    localparam int BIT = 32;
    // Pulse latency from rx start edge: centre of stop bit (9.5 bits) plus
    // 2-flop sync, edge-detect register, first tick, M+1 vote tick and the
    // output register.
    localparam int LAT = 9 * BIT + BIT / 2 + 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       o_received;
    logic [7:0] o_rx_byte;
    logic       o_is_receiving;
    logic       o_recv_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rx     = 0;
    int n_err    = 0;
    int n_both   = 0;
    int last_rx_cyc = 0;
    logic [7:0] rx_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ  (3200000),
        .BAUD_RATE (100000),
        .OVERSAMPLE(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx          (rx),
        .o_received    (o_received),
        .o_rx_byte     (o_rx_byte),
        .o_is_receiving(o_is_receiving),
        .o_recv_error  (o_recv_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_received) begin
            n_rx++;
            rx_q.push_back(o_rx_byte);
            last_rx_cyc = cyc;
        end
        if (o_recv_error) n_err++;
        if (o_received && o_recv_error) n_both++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_b;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        int base_rx;
        int base_err;
        int c0;
        int lat;
        int w;

        // Reset with rx toggling
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            rx = ~rx;
        end
        chk_eq("rst_received", 32'(o_received), 32'd0);
        chk_eq("rst_error", 32'(o_recv_error), 32'd0);
        chk_eq("rst_rx_byte", 32'(o_rx_byte), 32'h00);
        chk_eq("rst_is_receiving", 32'(o_is_receiving), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk_eq("idle_no_received", 32'(n_rx), 32'd0);
        chk_eq("idle_no_error", 32'(n_err), 32'd0);
        chk_eq("idle_is_receiving", 32'(o_is_receiving), 32'd0);

        // Reset in the middle of a frame
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        chk_eq("midrst_busy_before", 32'(o_is_receiving), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        chk_eq("midrst_no_received", 32'(n_rx), 32'd0);
        chk_eq("midrst_no_error", 32'(n_err), 32'd0);
        chk_eq("midrst_rx_byte", 32'(o_rx_byte), 32'h00);
        chk_eq("midrst_idle", 32'(o_is_receiving), 32'd0);

        // Single frame A5
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (BIT) @(negedge clk);
        chk_eq("a5_count", 32'(n_rx), 32'd1);
        chk_eq("a5_byte", 32'(o_rx_byte), 32'hA5);
        chk_eq("a5_no_error", 32'(n_err), 32'd0);
        lat = last_rx_cyc - c0;
        chk_eq("a5_latency_window", 32'(lat >= LAT - 3 && lat <= LAT + 3), 32'd1);
        if (lat < LAT - 3 || lat > LAT + 3)
            $display("  a5 latency %0d clocks, window %0d..%0d", lat, LAT - 3, LAT + 3);
        repeat (2 * BIT) @(negedge clk);
        chk_eq("a5_byte_held", 32'(o_rx_byte), 32'hA5);

        // Back-to-back frames, one-bit stops, no idle gap
        base_rx = n_rx;
        rx_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (BIT) @(negedge clk);
        chk_eq("b2b_count", 32'(n_rx - base_rx), 32'd3);
        if (rx_q.size() == 3) begin
            chk_eq("b2b_byte0", 32'(rx_q[0]), 32'h00);
            chk_eq("b2b_byte1", 32'(rx_q[1]), 32'hFF);
            chk_eq("b2b_byte2", 32'(rx_q[2]), 32'h3C);
        end
        chk_eq("b2b_no_error", 32'(n_err), 32'd0);

        // Start glitch
        base_rx = n_rx;
        base_err = n_err;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk_eq("glitch_busy", 32'(o_is_receiving), 32'd1);
        rx = 1'b1;
        w = 0;
        while (o_is_receiving && w < BIT) begin
            @(negedge clk);
            w++;
        end
        chk_eq("glitch_back_idle", 32'(o_is_receiving), 32'd0);
        repeat (2 * BIT) @(negedge clk);
        chk_eq("glitch_no_received", 32'(n_rx - base_rx), 32'd0);
        chk_eq("glitch_no_error", 32'(n_err - base_err), 32'd0);

        // Framing error: stop = 0, line held low for 3 bit times
        base_rx = n_rx;
        base_err = n_err;
        send_frame(8'h55, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk_eq("ferr_error_count", 32'(n_err - base_err), 32'd1);
        chk_eq("ferr_no_received", 32'(n_rx - base_rx), 32'd0);
        chk_eq("ferr_byte_unchanged", 32'(o_rx_byte), 32'h3C);
        send_frame(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        chk_eq("after_ferr_count", 32'(n_rx - base_rx), 32'd1);
        chk_eq("after_ferr_byte", 32'(o_rx_byte), 32'h81);

        // Noise: invert rx for 2 clocks so that only sample 7 of data bit 2
        // sees it (frame offset 3 bits + 7 ticks + 2 clocks of sync/detect)
        base_rx = n_rx;
        base_err = n_err;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (3 * BIT + 2 * 7 + 2) @(negedge clk);
                rx = ~rx;
                repeat (2) @(negedge clk);
                rx = ~rx;
            end
        join
        repeat (BIT) @(negedge clk);
        chk_eq("noise_count", 32'(n_rx - base_rx), 32'd1);
        chk_eq("noise_byte", 32'(o_rx_byte), 32'hC3);
        chk_eq("noise_no_error", 32'(n_err - base_err), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 8'h01 with parity bit 0 (odd overall) then with parity bit 1
        base_rx = n_rx;
        base_err = n_err;
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        repeat (BIT) @(negedge clk);
        chk_eq("par_bad_error", 32'(n_err - base_err), 32'd1);
        chk_eq("par_bad_no_received", 32'(n_rx - base_rx), 32'd0);
        chk_eq("par_bad_byte_kept", 32'(o_rx_byte), 32'hC3);
        chk_eq("par_bad_idle", 32'(o_is_receiving), 32'd0);
        par_flip = 1'b0;
        send_frame(8'h01, 1'b1);
        repeat (BIT) @(negedge clk);
        chk_eq("par_good_received", 32'(n_rx - base_rx), 32'd1);
        chk_eq("par_good_byte", 32'(o_rx_byte), 32'h01);
        chk_eq("par_good_no_new_error", 32'(n_err - base_err), 32'd1);
`endif

        chk_eq("never_both_strobes", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
